// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM encoding,
// word geometry and the value returned on a failed fetch.
package imem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_CNT_W = $clog2(WORD_BYTES);
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Loader and fetch signals of the instruction memory. The master drives
// requests (loader/PC side); the slave is the memory itself.
interface instr_mem_loadable_if #(
    parameter int ADDR_W = 8
) ();

    logic              load_en;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              load_done;
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              inst_valid;
    logic [31:0]       inst_out;
    logic              fetch_err;

    modport master (
        output load_en, load_valid, load_byte, fetch_valid, fetch_addr,
        input  load_ready, load_done, fetch_ready, inst_valid, inst_out, fetch_err
    );

    modport slave (
        input  load_en, load_valid, load_byte, fetch_valid, fetch_addr,
        output load_ready, load_done, fetch_ready, inst_valid, inst_out, fetch_err
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Collects loader bytes big-endian into a 32-bit word; word_strobe is high
// in the cycle the final byte of a word arrives, with the full word on word.
module imem_byte_packer
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_strobe
);

    localparam int SHIFT_W = 8 * (WORD_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(WORD_BYTES - 1);

    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;

    assign word        = {shift_q, byte_in};
    assign word_strobe = byte_valid && (byte_cnt_q == LAST_BYTE);

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (byte_valid) begin
            shift_d    = {shift_q[SHIFT_W-9:0], byte_in};
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
        end
        // A clear drops any partial word; the counter wraps to 0 after the last byte anyway.
        if (clear) begin
            byte_cnt_d = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: byte-serial loader fills the word
// array, then fetches return one instruction per request one cycle later.
module instr_mem_loadable
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] NOP_WORD    = DEFAULT_NOP_WORD
) (
    input logic                  clk,
    input logic                  rst,
    instr_mem_loadable_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH_WORDS);

    state_e           state_q, state_d;
    logic             load_ready_q, load_ready_d;
    logic             load_done_q, load_done_d;
    logic             fetch_ready_q, fetch_ready_d;
    logic             inst_valid_q, inst_valid_d;
    logic             fetch_err_q, fetch_err_d;
    logic [31:0]      inst_out_q, inst_out_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] loaded_words_q, loaded_words_d;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             byte_accept;
    logic             packer_clear;
    logic             word_strobe;
    logic [31:0]      packed_word;
    logic             fetch_accept;
    logic             fetch_bad;
    logic [IDX_W-1:0] fetch_idx;

    // load_ready_q already encodes "in LOAD with room left", so no extra bound check here.
    assign byte_accept  = (state_q == ST_LOAD) && bus.load_valid && load_ready_q;
    assign packer_clear = (state_q != ST_LOAD) || !bus.load_en;

    imem_byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (packer_clear),
        .byte_valid  (byte_accept),
        .byte_in     (bus.load_byte),
        .word        (packed_word),
        .word_strobe (word_strobe)
    );

    assign fetch_accept = bus.fetch_valid && fetch_ready_q;
    assign fetch_idx    = bus.fetch_addr[IDX_W+1:2];
    assign fetch_bad    = (bus.fetch_addr[1:0] != 2'b00) || ({1'b0, fetch_idx} >= loaded_words_q);

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        loaded_words_d = loaded_words_q;
        load_done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.load_en) begin
                    state_d        = ST_LOAD;
                    wr_ptr_d       = '0;
                    loaded_words_d = '0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (word_strobe) begin
                    wr_ptr_d       = wr_ptr_q + PTR_W'(1);
                    loaded_words_d = wr_ptr_q + PTR_W'(1);
                end
                if (!bus.load_en) begin
                    state_d     = ST_RUN;
                    load_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next-state view so they line up with state_q.
        load_ready_d  = (state_d == ST_LOAD) && (wr_ptr_d < DEPTH_CNT);
        fetch_ready_d = (state_d == ST_RUN);

        inst_valid_d = fetch_accept;
        fetch_err_d  = fetch_err_q;
        inst_out_d   = inst_out_q;
        if (fetch_accept) begin
            fetch_err_d = fetch_bad;
            inst_out_d  = fetch_bad ? NOP_WORD : mem[fetch_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            load_ready_q   <= 1'b0;
            load_done_q    <= 1'b0;
            fetch_ready_q  <= 1'b0;
            inst_valid_q   <= 1'b0;
            fetch_err_q    <= 1'b0;
            inst_out_q     <= NOP_WORD;
            wr_ptr_q       <= '0;
            loaded_words_q <= '0;
        end else begin
            state_q        <= state_d;
            load_ready_q   <= load_ready_d;
            load_done_q    <= load_done_d;
            fetch_ready_q  <= fetch_ready_d;
            inst_valid_q   <= inst_valid_d;
            fetch_err_q    <= fetch_err_d;
            inst_out_q     <= inst_out_d;
            wr_ptr_q       <= wr_ptr_d;
            loaded_words_q <= loaded_words_d;
        end
    end

    // NOTE: storage has no reset; loaded_words_q alone decides which words are valid.
    always_ff @(posedge clk) begin
        if (word_strobe) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= packed_word;
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.load_done   = load_done_q;
    assign bus.fetch_ready = fetch_ready_q;
    assign bus.inst_valid  = inst_valid_q;
    assign bus.inst_out    = inst_out_q;
    assign bus.fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed + randomized bench for instr_mem_loadable against a byte-list
// reference model of the loaded program image.
module tb_instr_mem_loadable;

    localparam int          DEPTH = 16;
    localparam int          AW    = 6;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [DEPTH];
    int          ref_loaded = 0;
    logic [7:0]  sess_q [$];

    instr_mem_loadable_if #(.ADDR_W(AW)) bus ();

    instr_mem_loadable #(
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (AW),
        .NOP_WORD    (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a fetch is good only for an aligned address inside the loaded image.
    function automatic void model_fetch(input int addr, output logic err, output logic [31:0] w);
        if ((addr % 4) != 0 || (addr / 4) >= ref_loaded) begin
            err = 1'b1;
            w   = NOP;
        end else begin
            err = 1'b0;
            w   = ref_mem[addr / 4];
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, " load_ready"},  32'(bus.load_ready),  32'd0);
        check({tag, " load_done"},   32'(bus.load_done),   32'd0);
        check({tag, " fetch_ready"}, 32'(bus.fetch_ready), 32'd0);
        check({tag, " inst_valid"},  32'(bus.inst_valid),  32'd0);
        check({tag, " fetch_err"},   32'(bus.fetch_err),   32'd0);
        check({tag, " inst_out"},    bus.inst_out,         NOP);
    endtask

    // Back-to-back fetches; each result is checked the cycle after its request.
    task automatic fetch_burst(input string tag, input int addrs [$]);
        logic        exp_err;
        logic [31:0] exp_w;
        exp_w = NOP;
        check({tag, " fetch_ready"}, 32'(bus.fetch_ready), 32'd1);
        for (int i = 0; i < addrs.size(); i++) begin
            bus.fetch_valid = 1'b1;
            bus.fetch_addr  = AW'(addrs[i]);
            model_fetch(addrs[i], exp_err, exp_w);
            step();
            check($sformatf("%s inst_valid@%0h", tag, addrs[i]), 32'(bus.inst_valid), 32'd1);
            check($sformatf("%s fetch_err@%0h", tag, addrs[i]),  32'(bus.fetch_err),  32'(exp_err));
            check($sformatf("%s inst_out@%0h", tag, addrs[i]),   bus.inst_out,        exp_w);
        end
        bus.fetch_valid = 1'b0;
        step();
        check({tag, " inst_valid idle"}, 32'(bus.inst_valid), 32'd0);
        check({tag, " inst_out hold"},   bus.inst_out,        exp_w);
    endtask

    task automatic begin_load(input string tag, input logic with_fetch, input int faddr);
        logic        exp_err;
        logic [31:0] exp_w;
        exp_err = 1'b0;
        exp_w   = NOP;
        bus.load_en = 1'b1;
        if (with_fetch) begin
            bus.fetch_valid = 1'b1;
            bus.fetch_addr  = AW'(faddr);
            model_fetch(faddr, exp_err, exp_w);
        end
        step();
        bus.fetch_valid = 1'b0;
        if (with_fetch) begin
            check({tag, " overlap inst_valid"}, 32'(bus.inst_valid), 32'd1);
            check({tag, " overlap fetch_err"},  32'(bus.fetch_err),  32'(exp_err));
            check({tag, " overlap inst_out"},   bus.inst_out,        exp_w);
        end
        check({tag, " load_ready on entry"},  32'(bus.load_ready),  32'd1);
        check({tag, " fetch_ready in load"},  32'(bus.fetch_ready), 32'd0);
        sess_q.delete();
    endtask

    // Each byte is offered for exactly one cycle; the model accepts it only while the array has room.
    task automatic send_bytes(input string tag, input logic [7:0] bytes [$]);
        for (int i = 0; i < bytes.size(); i++) begin
            bus.load_valid = 1'b1;
            bus.load_byte  = bytes[i];
            if (sess_q.size() < 4 * DEPTH) sess_q.push_back(bytes[i]);
            step();
            check($sformatf("%s load_ready after byte %0d", tag, i),
                  32'(bus.load_ready), 32'(sess_q.size() < 4 * DEPTH));
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic end_load(input string tag);
        int nw;
        bus.load_en = 1'b0;
        step();
        check({tag, " load_done pulse"}, 32'(bus.load_done),   32'd1);
        check({tag, " fetch_ready run"}, 32'(bus.fetch_ready), 32'd1);
        check({tag, " load_ready exit"}, 32'(bus.load_ready),  32'd0);
        nw = sess_q.size() / 4;
        for (int w = 0; w < nw; w++) begin
            ref_mem[w] = {sess_q[4*w], sess_q[4*w+1], sess_q[4*w+2], sess_q[4*w+3]};
        end
        ref_loaded = nw;
        step();
        check({tag, " load_done cleared"}, 32'(bus.load_done), 32'd0);
    endtask

    function automatic void rand_bytes(input int n, output logic [7:0] q [$]);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endfunction

    initial begin
        logic [7:0] bq [$];
        int         aq [$];

        bus.load_en     = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_byte   = 8'h00;
        bus.fetch_valid = 1'b0;
        bus.fetch_addr  = '0;

        #2 rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        step();

        // T1: nothing loaded, every fetch errors
        aq.delete(); aq.push_back(0);
        fetch_burst("t1", aq);

        // T2: two-word program
        begin_load("t2", 1'b0, 0);
        bq.delete();
        bq.push_back(8'hFC); bq.push_back(8'h20); bq.push_back(8'h00); bq.push_back(8'h08);
        bq.push_back(8'h00); bq.push_back(8'h01); bq.push_back(8'h10); bq.push_back(8'h20);
        send_bytes("t2", bq);
        end_load("t2");
        check("t2 model word0", ref_mem[0], 32'hFC20_0008);
        aq.delete(); aq.push_back(0); aq.push_back(4);
        fetch_burst("t2", aq);

        // T3: misaligned and past-image fetches
        aq.delete(); aq.push_back(2); aq.push_back(8);
        fetch_burst("t3", aq);

        // T4: overfill with a fetch issued in the same cycle load_en rises
        begin_load("t4", 1'b1, 4);
        rand_bytes(4 * DEPTH + 3, bq);
        send_bytes("t4", bq);
        end_load("t4");
        aq.delete(); aq.push_back(0); aq.push_back(4 * (DEPTH - 1));
        fetch_burst("t4", aq);
        aq.delete();
        for (int i = 0; i < 20; i++) aq.push_back(int'($urandom_range(0, 4 * DEPTH - 1)));
        fetch_burst("t4 rand", aq);

        // T5: trailing partial word is dropped
        begin_load("t5", 1'b0, 0);
        rand_bytes(6, bq);
        send_bytes("t5", bq);
        end_load("t5");
        aq.delete(); aq.push_back(0); aq.push_back(4);
        for (int i = 0; i < 8; i++) aq.push_back(int'($urandom_range(0, 4 * DEPTH - 1)));
        aq.push_back(0);
        fetch_burst("t5", aq);

        // T6: asynchronous reset in the middle of a load
        begin_load("t6", 1'b0, 0);
        rand_bytes(5, bq);
        send_bytes("t6", bq);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("t6 reset");
        ref_loaded = 0;
        sess_q.delete();
        bus.load_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        aq.delete(); aq.push_back(0); aq.push_back(4);
        fetch_burst("t6", aq);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
